mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 132 +++++++++++++
 tb/tb_mmio_uart_tx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a small byte FIFO written by CPU stores
// and a START/DATA/STOP shifter that drains it LSB first.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   addr,
  input  logic [31:0]                   wdata,
  input  logic                          memWrite,
  output logic [31:0]                   rdata,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bitIdx;
  logic [7:0]      r_shift;

  logic            w_bitDone;
  logic            w_notEmpty;
  logic            w_full;
  logic            w_pop;
  logic            w_dataWr;
  logic            w_ctrlWr;
  logic            w_push;
  logic            w_drop;

  assign w_bitDone  = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_notEmpty = (r_count != '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_dataWr   = memWrite && (addr == BASE_ADDR);
  assign w_ctrlWr   = memWrite && (addr == BASE_ADDR + 32'd4);

  // A pop happens whenever the shifter is ready for a new frame; a push into a
  // full FIFO is still accepted when it coincides with that pop.
  assign w_pop  = w_notEmpty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bitDone));
  assign w_push = w_dataWr && (!w_full || w_pop);
  assign w_drop = w_dataWr && !w_push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_notEmpty) w_nextState = S_START;
      S_START: if (w_bitDone) w_nextState = S_DATA;
      S_DATA:  if (w_bitDone && (r_bitIdx == 3'd7)) w_nextState = S_STOP;
      S_STOP:  if (w_bitDone) w_nextState = w_notEmpty ? S_START : S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    txd  = 1'b1;
    busy = (r_state != S_IDLE);
    case (r_state)
      S_START: txd = 1'b0;
      S_DATA:  txd = r_shift[0];
      default: txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_baud   <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
    end else begin
      if ((w_nextState != r_state) || w_bitDone) r_baud <= '0;
      else if (r_state != S_IDLE)                r_baud <= r_baud + BW'(1);

      if (w_nextState != r_state)             r_bitIdx <= '0;
      else if ((r_state == S_DATA) && w_bitDone) r_bitIdx <= r_bitIdx + 3'd1;

      if (w_pop)                                 r_shift <= r_mem[r_rptr];
      else if ((r_state == S_DATA) && w_bitDone) r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)                    r_overflow <= 1'b1;
      else if (w_ctrlWr && wdata[0]) r_overflow <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (addr == BASE_ADDR + 32'd4)
      rdata = {28'h0, r_overflow, w_full, ~w_notEmpty, busy};
  end

  assign fifo_count = r_count;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=0x100.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        memWrite;
  logic [31:0] rdata;
  logic        txd;
  logic        busy;
  logic [2:0]  fifo_count;

  int checkCount = 0;
  int errorCount = 0;
  logic [7:0] expBytes [8];
  logic sawLow;

  mmio_uart_tx #(
    .BASE_ADDR(32'h0000_0100),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .wdata(wdata),
    .memWrite(memWrite),
    .rdata(rdata),
    .txd(txd),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One store on the next rising edge; returns #1 after that edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr     = a;
    wdata    = d;
    memWrite = 1'b1;
    @(posedge clk);
    #1;
    memWrite = 1'b0;
  endtask

  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected line level t cycles after the first START of a back-to-back run.
  function automatic logic expBit(input int t);
    int f;
    int s;
    f = t / 40;
    s = (t % 40) / 4;
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return expBytes[f][s-1];
  endfunction

  task automatic checkStream(input int nBytes, input int tStart);
    for (int t = tStart; t < nBytes * 40; t++) begin
      checkOutput($sformatf("txd t=%0d", t), {31'h0, txd}, {31'h0, expBit(t)});
      @(posedge clk);
      #1;
    end
    checkOutput("busyAfterStream", {31'h0, busy}, 32'h0);
    checkOutput("txdAfterStream", {31'h0, txd}, 32'h1);
  endtask

  initial begin
    reset    = 1'b0;
    memWrite = 1'b0;
    addr     = 32'h104;
    wdata    = 32'h0;
    #3;
    checkOutput("resetTxd", {31'h0, txd}, 32'h1);
    checkOutput("resetBusy", {31'h0, busy}, 32'h0);
    checkOutput("resetCount", {29'h0, fifo_count}, 32'h0);
    checkOutput("resetStatus", rdata, 32'h2);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stepCycles(2);

    // Single byte with exact latency and bit timing
    applyStimulus(32'h100, 32'hA5);
    checkOutput("latencyIdle", {31'h0, txd}, 32'h1);
    checkOutput("singleCount", {29'h0, fifo_count}, 32'h1);
    stepCycles(1);
    checkOutput("singlePopped", {29'h0, fifo_count}, 32'h0);
    expBytes[0] = 8'hA5;
    checkStream(1, 0);

    // Six stores on consecutive edges: the sixth hits a full FIFO
    for (int i = 1; i <= 6; i++) applyStimulus(32'h100, i);
    addr = 32'h104;
    #1;
    checkOutput("ovfCount", {29'h0, fifo_count}, 32'h4);
    checkOutput("ovfStatusBusy", rdata, 32'hD);
    for (int i = 0; i < 5; i++) expBytes[i] = 8'(i + 1);
    checkStream(5, 4);
    checkOutput("ovfStatusIdle", rdata, 32'hA);

    // Clear overflow, then address decode and strobe qualification
    applyStimulus(32'h104, 32'h1);
    checkOutput("ovfCleared", rdata, 32'h2);
    applyStimulus(32'h200, 32'hAA);
    checkOutput("otherAddrCount", {29'h0, fifo_count}, 32'h0);
    checkOutput("otherAddrRdata", rdata, 32'h0);
    addr  = 32'h100;
    wdata = 32'hBB;
    sawLow = 1'b0;
    for (int i = 0; i < 12; i++) begin
      stepCycles(1);
      if (txd !== 1'b1) sawLow = 1'b1;
    end
    checkOutput("noStrobeIdle", {31'h0, sawLow}, 32'h0);
    checkOutput("noStrobeCount", {29'h0, fifo_count}, 32'h0);
    checkOutput("noStrobeBusy", {31'h0, busy}, 32'h0);

    // Asynchronous reset while shifting 0x55 with two bytes queued
    applyStimulus(32'h100, 32'h55);
    applyStimulus(32'h100, 32'h66);
    applyStimulus(32'h100, 32'h77);
    stepCycles(7);
    checkOutput("midFrameBit1", {31'h0, txd}, 32'h0);
    checkOutput("midFrameCount", {29'h0, fifo_count}, 32'h2);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abortTxd", {31'h0, txd}, 32'h1);
    checkOutput("abortBusy", {31'h0, busy}, 32'h0);
    checkOutput("abortCount", {29'h0, fifo_count}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    sawLow = 1'b0;
    for (int i = 0; i < 120; i++) begin
      stepCycles(1);
      if (txd !== 1'b1) sawLow = 1'b1;
    end
    checkOutput("postResetIdle", {31'h0, sawLow}, 32'h0);
    checkOutput("postResetCount", {29'h0, fifo_count}, 32'h0);

    // Push into a full FIFO on the same edge the STOP bit ends and pops
    for (int i = 0; i < 5; i++) applyStimulus(32'h100, 32'h11 * (i + 1));
    checkOutput("fullCount", {29'h0, fifo_count}, 32'h4);
    stepCycles(36);
    applyStimulus(32'h100, 32'h66);
    addr = 32'h104;
    #1;
    checkOutput("pushPopCount", {29'h0, fifo_count}, 32'h4);
    checkOutput("pushPopStatus", rdata, 32'h5);
    for (int i = 0; i < 6; i++) expBytes[i] = 8'(8'h11 * (i + 1));
    checkStream(6, 40);
    checkOutput("pushPopFinalStatus", rdata, 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
